// File: rtl/sig_result_engine.sv
// Result back end of the signature authenticator: gathers LANES AES block results plus the
// reference digest, then either streams ciphertext words (encrypt) or emits one compare verdict (decrypt).
module sig_result_engine #(
  parameter int LANES     = 2,
  parameter int AES_BW    = 128,
  parameter int OUT_BW    = 64,
  parameter int BYTE_FLIP = 1
) (
  input  logic                    clk,
  input  logic                    srst_n,
  input  logic                    start,
  input  logic                    mode,
  input  logic [LANES*AES_BW-1:0] digest_i,
  input  logic                    digest_done,
  input  logic [LANES*AES_BW-1:0] aes_data_i,
  input  logic [LANES-1:0]        aes_done_i,
  input  logic                    out_ready,
  output logic [OUT_BW-1:0]       result,
  output logic                    valid,
  output logic                    last,
  output logic                    verify,
  output logic                    busy
);

  localparam int DW = LANES * AES_BW;
  localparam int W  = DW / OUT_BW;
  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_SEND, S_CMP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_mode;
  logic              r_dig_flag;
  logic [LANES-1:0]  r_lane_flag;
  logic [DW-1:0]     r_data;
  logic [DW-1:0]     r_digest;
  logic [IW-1:0]     r_index;
  logic [DW-1:0]     w_digest_cap;
  logic [OUT_BW-1:0] w_word;
  logic              w_dig_take;
  logic              w_complete;

  // Digest bits are reversed within each byte so it lines up with the AES byte ordering.
  always_comb begin
    w_digest_cap = digest_i;
    if (BYTE_FLIP != 0) begin
      for (int b = 0; b < DW / 8; b++) begin
        for (int i = 0; i < 8; i++) begin
          w_digest_cap[b*8+i] = digest_i[b*8+7-i];
        end
      end
    end
  end

  assign w_dig_take = digest_done && (r_state == S_IDLE || r_state == S_COLLECT);
  // Flags are OR'd with this cycle's pulses so the final capture and the transition share an edge.
  assign w_complete = (r_state == S_COLLECT) && (&(r_lane_flag | aes_done_i)) &&
                      (!r_mode || r_dig_flag || digest_done);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (start) w_next = S_COLLECT;
      S_COLLECT: if (w_complete) w_next = r_mode ? S_CMP : S_SEND;
      S_SEND:    if (out_ready && r_index == LAST_IDX) w_next = S_IDLE;
      S_CMP:     if (out_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_word = '0;
    for (int w = 0; w < W; w++) begin
      if (r_index == IW'(w)) w_word = r_data[DW-1-w*OUT_BW -: OUT_BW];
    end
  end

  always_comb begin
    result = '0;
    valid  = 1'b0;
    last   = 1'b0;
    verify = 1'b0;
    busy   = (r_state != S_IDLE);
    if (r_state == S_SEND) begin
      valid  = 1'b1;
      result = w_word;
      last   = (r_index == LAST_IDX);
    end else if (r_state == S_CMP) begin
      valid  = 1'b1;
      last   = 1'b1;
      result = r_data[DW-1 -: OUT_BW];
      verify = (r_data == r_digest);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!srst_n) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    // NOTE: data registers are wide but few, so they are cleared with the control state.
    if (!srst_n) begin
      r_mode      <= 1'b0;
      r_dig_flag  <= 1'b0;
      r_lane_flag <= '0;
      r_data      <= '0;
      r_digest    <= '0;
      r_index     <= '0;
    end else begin
      if (w_dig_take) begin
        r_digest   <= w_digest_cap;
        r_dig_flag <= 1'b1;
      end
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mode      <= mode;
            r_lane_flag <= '0;
          end
        end
        S_COLLECT: begin
          for (int k = 0; k < LANES; k++) begin
            if (aes_done_i[k] && !r_lane_flag[k]) begin
              r_data[(LANES-k)*AES_BW-1 -: AES_BW] <= aes_data_i[(LANES-k)*AES_BW-1 -: AES_BW];
              r_lane_flag[k] <= 1'b1;
            end
          end
          if (w_complete) r_index <= '0;
        end
        S_SEND: begin
          if (out_ready) r_index <= (r_index == LAST_IDX) ? '0 : r_index + 1'b1;
        end
        S_CMP: begin
          if (out_ready) r_dig_flag <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sig_result_engine.sv
// Directed bench for sig_result_engine: a cycle table for streaming/backpressure plus
// hand sequences for verify pass/fail, repeat pulses, ignored start and mid-job reset.
module tb_sig_result_engine;

  logic         clk = 1'b0;
  logic         srst_n = 1'b0;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic [255:0] digest_i = '0;
  logic         digest_done = 1'b0;
  logic [255:0] aes_data_i = '0;
  logic [1:0]   aes_done_i = '0;
  logic         out_ready = 1'b0;
  logic [63:0]  result;
  logic         valid, last, verify, busy;

  int checks = 0;
  int failures = 0;

  localparam logic [127:0] L0 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] L1 = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [63:0]  W0 = 64'h0011223344556677;
  localparam logic [63:0]  W1 = 64'h8899AABBCCDDEEFF;
  localparam logic [63:0]  W2 = 64'h0123456789ABCDEF;
  localparam logic [63:0]  W3 = 64'hFEDCBA9876543210;
  localparam logic [63:0]  P01 = 64'h0101010101010101;

  sig_result_engine #(.LANES(2), .AES_BW(128), .OUT_BW(64), .BYTE_FLIP(1)) dut (
    .clk(clk), .srst_n(srst_n), .start(start), .mode(mode),
    .digest_i(digest_i), .digest_done(digest_done),
    .aes_data_i(aes_data_i), .aes_done_i(aes_done_i), .out_ready(out_ready),
    .result(result), .valid(valid), .last(last), .verify(verify), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       mode;
    logic [1:0] aes_done;
    logic       ready;
    logic       ev;
    logic       el;
    logic       eb;
    logic [63:0] er;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic s, input logic m, input logic [1:0] a, input logic r,
                              input logic ev, input logic el, input logic eb, input logic [63:0] er);
    vec_t v;
    v.start = s; v.mode = m; v.aes_done = a; v.ready = r;
    v.ev = ev; v.el = el; v.eb = eb; v.er = er;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic ev, input logic el, input logic ever,
                            input logic eb, input logic [63:0] er);
    check($sformatf("%s.valid", tag), {63'd0, valid}, {63'd0, ev});
    check($sformatf("%s.last", tag), {63'd0, last}, {63'd0, el});
    check($sformatf("%s.verify", tag), {63'd0, verify}, {63'd0, ever});
    check($sformatf("%s.busy", tag), {63'd0, busy}, {63'd0, eb});
    check($sformatf("%s.result", tag), result, er);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Scenario 1: same-cycle lanes, out_ready high; mode toggled after start must not matter.
    tbl.push_back(mk(1, 0, 2'b00, 1, 0, 0, 0, '0));
    tbl.push_back(mk(0, 1, 2'b11, 1, 0, 0, 1, '0));
    tbl.push_back(mk(0, 0, 2'b00, 1, 1, 0, 1, W0));
    tbl.push_back(mk(0, 0, 2'b00, 1, 1, 0, 1, W1));
    tbl.push_back(mk(0, 0, 2'b00, 1, 1, 0, 1, W2));
    tbl.push_back(mk(0, 0, 2'b00, 1, 1, 1, 1, W3));
    tbl.push_back(mk(0, 0, 2'b00, 1, 0, 0, 0, '0));
    // Scenario 2: lane1 three cycles before lane0, out_ready 1,0,0,1,1,0,1.
    tbl.push_back(mk(1, 0, 2'b00, 0, 0, 0, 0, '0));
    tbl.push_back(mk(0, 0, 2'b10, 0, 0, 0, 1, '0));
    tbl.push_back(mk(0, 0, 2'b00, 0, 0, 0, 1, '0));
    tbl.push_back(mk(0, 0, 2'b00, 0, 0, 0, 1, '0));
    tbl.push_back(mk(0, 0, 2'b01, 0, 0, 0, 1, '0));
    tbl.push_back(mk(0, 0, 2'b00, 1, 1, 0, 1, W0));
    tbl.push_back(mk(0, 0, 2'b00, 0, 1, 0, 1, W1));
    tbl.push_back(mk(0, 0, 2'b00, 0, 1, 0, 1, W1));
    tbl.push_back(mk(0, 0, 2'b00, 1, 1, 0, 1, W1));
    tbl.push_back(mk(0, 0, 2'b00, 1, 1, 0, 1, W2));
    tbl.push_back(mk(0, 0, 2'b00, 0, 1, 1, 1, W3));
    tbl.push_back(mk(0, 0, 2'b00, 1, 1, 1, 1, W3));
    tbl.push_back(mk(0, 0, 2'b00, 0, 0, 0, 0, '0));

    // Reset state
    tick(); tick();
    expect_out("reset", 0, 0, 0, 0, '0);
    srst_n = 1'b1;

    aes_data_i = {L0, L1};
    foreach (tbl[i]) begin
      start = tbl[i].start; mode = tbl[i].mode;
      aes_done_i = tbl[i].aes_done; out_ready = tbl[i].ready;
      expect_out($sformatf("row%0d", i), tbl[i].ev, tbl[i].el, 1'b0, tbl[i].eb, tbl[i].er);
      tick();
    end
    start = 0; mode = 0; aes_done_i = '0; out_ready = 0;

    // Scenario 3: verify pass with byte-flipped digest 0x80 -> 0x01
    digest_i = {32{8'h80}}; digest_done = 1; tick(); digest_done = 0;
    start = 1; mode = 1; tick(); start = 0; mode = 0;
    aes_data_i = {32{8'h01}}; aes_done_i = 2'b11; out_ready = 1; tick(); aes_done_i = '0;
    expect_out("vpass", 1, 1, 1, 1, P01);
    tick();
    expect_out("vpass_done", 0, 0, 0, 0, '0);
    // Follow-up: no fresh digest, so the job waits in COLLECT
    start = 1; mode = 1; tick(); start = 0; mode = 0;
    aes_done_i = 2'b11; tick(); aes_done_i = '0;
    tick(); tick();
    expect_out("nodig_wait", 0, 0, 0, 1, '0);
    digest_done = 1; tick(); digest_done = 0;
    expect_out("late_dig", 1, 1, 1, 1, P01);
    tick();
    expect_out("late_dig_done", 0, 0, 0, 0, '0);

    // Scenario 4: verify fail, lane1 bit 0 inverted; held under backpressure
    digest_done = 1; tick(); digest_done = 0;
    start = 1; mode = 1; tick(); start = 0; mode = 0;
    aes_data_i = {32{8'h01}} ^ 256'h1; aes_done_i = 2'b11; out_ready = 0; tick(); aes_done_i = '0;
    expect_out("vfail", 1, 1, 0, 1, P01);
    tick();
    expect_out("vfail_hold", 1, 1, 0, 1, P01);
    out_ready = 1; tick();
    expect_out("vfail_done", 0, 0, 0, 0, '0);

    // Scenario 5: repeat lane0 pulse ignored; start during SEND ignored
    start = 1; mode = 0; tick(); start = 0;
    aes_data_i = {L0, L1}; aes_done_i = 2'b01; tick();
    aes_data_i = {~L0, L1}; aes_done_i = 2'b01; tick();
    aes_done_i = 2'b10; tick(); aes_done_i = '0;
    expect_out("rep_w0", 1, 0, 0, 1, W0);
    tick();
    expect_out("rep_w1", 1, 0, 0, 1, W1);
    start = 1; mode = 1; tick(); start = 0; mode = 0;
    expect_out("rep_w2", 1, 0, 0, 1, W2);
    tick();
    expect_out("rep_w3", 1, 1, 0, 1, W3);
    tick();
    expect_out("rep_idle", 0, 0, 0, 0, '0);
    tick();
    expect_out("rep_nojob", 0, 0, 0, 0, '0);

    // Scenario 6: reset during SEND at index 2, then a fresh job
    aes_data_i = {L0, L1};
    start = 1; tick(); start = 0;
    aes_done_i = 2'b11; tick(); aes_done_i = '0;
    tick(); tick();
    expect_out("rst_w2", 1, 0, 0, 1, W2);
    srst_n = 0; tick(); srst_n = 1;
    expect_out("rst_after", 0, 0, 0, 0, '0);
    tick();
    expect_out("rst_idle", 0, 0, 0, 0, '0);
    start = 1; tick(); start = 0;
    aes_done_i = 2'b11; tick(); aes_done_i = '0;
    expect_out("fresh_w0", 1, 0, 0, 1, W0);
    tick();
    expect_out("fresh_w1", 1, 0, 0, 1, W1);
    tick();
    expect_out("fresh_w2", 1, 0, 0, 1, W2);
    tick();
    expect_out("fresh_w3", 1, 1, 0, 1, W3);
    tick();
    expect_out("fresh_idle", 0, 0, 0, 0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
